// File: rtl/lane_pkg.sv
// Shared lane types for the lane_fifo elastic buffer and its lane-array consumers.
package lane_pkg;

  localparam int unsigned LaneWidth = 4;

  typedef logic [LaneWidth-1:0] lane_data_t;

endpackage

// File: rtl/lane_fifo_ptr.sv
// Wrapping FIFO pointer: increments modulo DEPTH (power of two), synchronous clear.
module lane_fifo_ptr #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_d, ptr_q;

  // Clear wins over increment; natural overflow provides the modulo-DEPTH wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PtrW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/lane_fifo.sv
// Elastic valid/ready buffer in front of the lane array, with occupancy count.
// Optional same-cycle pass-through when empty: define LANE_FIFO_BYPASS_EN.
module lane_fifo
  import lane_pkg::*;
#(
  parameter  int unsigned WIDTH = LaneWidth,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned LvlW  = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LvlW-1:0]  level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [LvlW-1:0]  level_d, level_q;
  logic             empty, full, push, pop, pass;

  assign empty = (level_q == '0);
  assign full  = (level_q == LvlW'(DEPTH));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    ready_o = !full;
    valid_o = !empty;
    data_o  = empty ? '0 : mem_q[rd_ptr];
    pass    = 1'b0;
`ifdef LANE_FIFO_BYPASS_EN
    // Empty and not flushing: show the producer word directly; consumed words skip storage.
    if (empty && !flush_i) begin
      valid_o = valid_i;
      data_o  = data_i;
      pass    = valid_i && ready_i;
    end
`endif
    push = valid_i && !full && !flush_i && !pass;
    pop  = !empty && ready_i && !flush_i;
  end

  always_comb begin
    level_d = level_q;
    if (flush_i) begin
      level_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; data_o is masked to zero while empty, so stale entries never show.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  lane_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (push),
    .ptr_o  (wr_ptr)
  );

  lane_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (pop),
    .ptr_o  (rd_ptr)
  );

  assign level_o = level_q;

endmodule

// File: tb/tb_lane_fifo.sv
// Self-checking bench for lane_fifo: a vector table for fill/full/drain plus
// scoreboard-driven sequences for wrap, flush, async reset and bypass.
module tb_lane_fifo;
  import lane_pkg::*;

  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  lane_data_t data_i = '0;
  logic       ready_o, valid_o;
  lane_data_t data_o;
  logic [2:0] level_o;

  int n_cmp  = 0;
  int n_fail = 0;

  lane_data_t sb_q[$];

  always #5 clk = ~clk;

  lane_fifo #(.WIDTH(LaneWidth), .DEPTH(Depth)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .level_o (level_o)
  );

  typedef struct {
    logic       flush;
    logic       valid;
    lane_data_t data;
    logic       ready;
    int         exp_level;
    logic       exp_ready;
    logic       exp_valid;
    lane_data_t exp_data;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, input logic v, input lane_data_t d, input logic r);
    flush_i = f;
    valid_i = v;
    data_i  = d;
    ready_i = r;
  endtask

  // One clock with scoreboard bookkeeping; outputs are sampled at the falling edge.
  task automatic cycle(input logic f, input logic v, input lane_data_t d, input logic r);
    bit         do_push, do_pop, do_pass;
    lane_data_t exp_word;
    drive(f, v, d, r);
    @(negedge clk);
    do_pass = 1'b0;
`ifdef LANE_FIFO_BYPASS_EN
    do_pass = (sb_q.size() == 0) && !f && v && r;
`endif
    do_push = v && (sb_q.size() < Depth) && !f && !do_pass;
    do_pop  = (sb_q.size() != 0) && r && !f;
    check("level", int'(level_o), sb_q.size());
    check("ready_o", int'(ready_o), int'(sb_q.size() != Depth));
    if (do_pass) begin
      check("bypass_valid", int'(valid_o), 1);
      check("bypass_data", int'(data_o), int'(d));
    end
    if (do_pop) begin
      exp_word = sb_q.pop_front();
      check("pop_valid", int'(valid_o), 1);
      check("pop_data", int'(data_o), int'(exp_word));
    end
    if (do_push) sb_q.push_back(d);
    if (f) sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill with ready_i low, full-with-pop, refill, then drain.
    tbl[0]  = '{1'b0, 1'b1, 4'hA, 1'b0, 0, 1'b1, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1, 1'b1, 1'b1, 4'hA};
    tbl[2]  = '{1'b0, 1'b1, 4'h3, 1'b0, 2, 1'b1, 1'b1, 4'hA};
    tbl[3]  = '{1'b0, 1'b1, 4'hC, 1'b0, 3, 1'b1, 1'b1, 4'hA};
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4, 1'b0, 1'b1, 4'hA};
    tbl[5]  = '{1'b0, 1'b1, 4'hF, 1'b0, 3, 1'b1, 1'b1, 4'h5};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4, 1'b0, 1'b1, 4'h5};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4, 1'b0, 1'b1, 4'h5};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3, 1'b1, 1'b1, 4'h3};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 2, 1'b1, 1'b1, 4'hC};
    tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 1, 1'b1, 1'b1, 4'hF};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 0, 1'b1, 1'b0, 4'h0};

    // Reset state while rst_ni is held low.
    #12;
    check("rst_level", int'(level_o), 0);
    check("rst_ready", int'(ready_o), 1);
    check("rst_valid", int'(valid_o), 0);
    check("rst_data", int'(data_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      vec_t       v;
      logic       ev;
      lane_data_t ed;
      v  = tbl[i];
      ev = v.exp_valid;
      ed = v.exp_data;
`ifdef LANE_FIFO_BYPASS_EN
      if (v.exp_level == 0 && !v.flush) begin
        ev = v.valid;
        ed = v.data;
      end
`endif
      drive(v.flush, v.valid, v.data, v.ready);
      @(negedge clk);
      check($sformatf("tbl%0d_level", i), int'(level_o), v.exp_level);
      check($sformatf("tbl%0d_ready", i), int'(ready_o), int'(v.exp_ready));
      check($sformatf("tbl%0d_valid", i), int'(valid_o), int'(ev));
      check($sformatf("tbl%0d_data", i), int'(data_o), int'(ed));
      @(posedge clk);
      #1;
    end

    // Stream 16 words at level 2 across pointer wrap.
    cycle(1'b0, 1'b1, 4'hE, 1'b0);
    cycle(1'b0, 1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, lane_data_t'(i), 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 1'b1);
    end
    check("drain_empty", sb_q.size(), 0);

    // Flush at level 3 with a simultaneous push of 4'h7.
    cycle(1'b0, 1'b1, 4'h1, 1'b0);
    cycle(1'b0, 1'b1, 4'h2, 1'b0);
    cycle(1'b0, 1'b1, 4'h4, 1'b0);
    cycle(1'b1, 1'b1, 4'h7, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    check("flush_level", int'(level_o), 0);
    check("flush_valid", int'(valid_o), 0);
    check("flush_data", int'(data_o), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 1'b1);
      check("flush_no_word", int'(valid_o), 0);
    end

    // Asynchronous reset mid-cycle at level 2.
    cycle(1'b0, 1'b1, 4'h6, 1'b0);
    cycle(1'b0, 1'b1, 4'h8, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    check("pre_rst_level", int'(level_o), 2);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", int'(valid_o), 0);
    check("async_rst_level", int'(level_o), 0);
    check("async_rst_ready", int'(ready_o), 1);
    sb_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Empty with valid_i and ready_i both high.
`ifdef LANE_FIFO_BYPASS_EN
    cycle(1'b0, 1'b1, 4'h9, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    check("bypass_level_after", int'(level_o), 0);
    check("bypass_valid_after", int'(valid_o), 0);
    @(posedge clk);
    #1;
`else
    drive(1'b0, 1'b1, 4'h9, 1'b1);
    #1;
    check("nobypass_same_valid", int'(valid_o), 0);
    check("nobypass_same_data", int'(data_o), 0);
    cycle(1'b0, 1'b1, 4'h9, 1'b1);
    check("nobypass_next_valid", int'(valid_o), 1);
    check("nobypass_next_data", int'(data_o), 9);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
`endif
    check("final_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_fifo.md
# lane_fifo

Small elastic buffer feeding the per-lane array (`top`/`sub` lane stage) on its `data_i` bus. It accepts WIDTH-bit lane words over a valid/ready handshake, stores up to DEPTH words, and presents them in order to the lane stage. This decouples a bursty producer from the lane array and provides an occupancy count for flow-control monitoring.

## Interface
- `WIDTH`, 4, lane word width; one bit per lane instance downstream.
- `DEPTH`, 4, storage entries; power of two, ≥ 2.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of all stored words.
- `valid_i`  in  1  producer word valid.
- `ready_o`  out  1  buffer can accept a word.
- `data_i`  in  WIDTH  producer word.
- `valid_o`  out  1  word available to lane stage.
- `ready_i`  in  1  lane stage accepts word.
- `data_o`  out  WIDTH  head word, drives lane array `data_i`.
- `level_o`  out  $clog2(DEPTH)+1  stored-word count, 0..DEPTH.

## Operation
- Push = `valid_i && ready_o`. Pop = `valid_o && ready_i`.
- `ready_o = (level != DEPTH)`. `valid_o = (level != 0)`, except in bypass (see Configuration).
- Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH without special casing.
- Level update: push only → +1; pop only → −1; both → unchanged; neither → unchanged.
- Full with pop and `valid_i`: `ready_o` is 0 that cycle, so there is no push. The pop frees an entry, and `ready_o` rises the next cycle.
- Empty without bypass: `valid_o` is 0, so a simultaneous push only writes storage.
- `data_o` = storage[rd_ptr] when `level != 0`, else all zeros. `data_o` never shows X.
- `flush_i` has priority over push and pop. Next cycle both pointers and `level_o` are 0. A push or pop in the flush cycle is discarded and does not change state.
- `valid_i` deasserting without a transfer is legal. Producer-side stability is not checked.
- Once `valid_o` is asserted, it and `data_o` stay stable until a pop or flush.

## Timing
- Reset (`rst_ni` low, async): pointers 0, `level_o` 0, `valid_o` 0, `ready_o` 1, `data_o` 0. Storage is not reset.
- Reset asserted mid-burst: all stored words are lost immediately. Outputs take reset values combinationally from the flop outputs.
- Push-to-`valid_o` latency: 1 cycle (0 in bypass when empty).
- Pop-to-`ready_o` recovery from full: 1 cycle.
- `level_o`, `ready_o`, `valid_o` are derived from registered state only (no `valid_i`/`ready_i` paths), except the bypass path.

## Configuration
- `LANE_FIFO_BYPASS_EN` defined: when `level == 0` and `!flush_i`:
  - `valid_o = valid_i` and `data_o = data_i`.
  - If `ready_i` is also 1, the word passes through in the same cycle and is not written to storage; the level stays 0.
  - If `ready_i` is 0, the word is written as a normal push.
- `LANE_FIFO_BYPASS_EN` undefined: no combinational input→output path. Minimum latency is 1 cycle.

## Structure
- Package `lane_pkg`:
  - `localparam int unsigned LaneWidth = 4`.
  - `typedef logic [LaneWidth-1:0] lane_data_t`.
  - `lane_fifo` defaults WIDTH from `LaneWidth`.
- Sub-module `lane_fifo_ptr`: wrapping pointer register with increment enable and synchronous clear. It is instantiated twice, as `u_wr_ptr` and `u_rd_ptr`.
- Storage is a flop array `DEPTH × WIDTH` inside `lane_fifo`. No RAM macro.

## Test plan
- Reset, then push 4'hA, 4'h5, 4'h3, 4'hC with `ready_i=0` → `level_o` 1,2,3,4. `ready_o` drops to 0 after the 4th push, and `data_o`=4'hA.
- Full, `ready_i=1` with `valid_i=1` (4'hF) → 4'hA popped, 4'hF not accepted, `level_o`=3. The next cycle `ready_o`=1 and 4'hF is pushed.
- Continuous push and pop for 16 words 4'h0..4'hF at level 2 → output order matches input exactly across pointer wrap. `level_o` stays 2.
- `flush_i` pulse at level 3 with simultaneous push 4'h7 → next cycle `level_o`=0, `valid_o`=0, `data_o`=0, and 4'h7 is never output.
- Assert `rst_ni` low mid-cycle at level 2 → `valid_o`=0, `level_o`=0, `ready_o`=1 immediately, without a clock edge.
- Empty, `valid_i=1` with 4'h9, `ready_i=1` → with `LANE_FIFO_BYPASS_EN`: `valid_o`=1 and `data_o`=4'h9 the same cycle, `level_o` stays 0. Without it: `valid_o`=1 with 4'h9 one cycle later.
